exc_ctrl: RTL

Precise exception/interrupt sequencer sitting between the commit stage and cp0: it decides which commit-stage event (interrupt, exception, ERET) is taken, and drives cp0's exception-write and clear-EXL inputs. It also flushes the pipeline and issues a redirect PC to fetch over a valid/ready handshake. It synchronizes raw hardware interrupt lines before they reach cp0.

---
 rtl/exc_ctrl_if.sv | 30 +++
 rtl/exc_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl_if.sv
// Commit-stage and fetch-redirect handshake bundle for exc_ctrl.
interface exc_ctrl_if;
  logic        commit_valid;
  logic        commit_ready;
  logic [31:0] commit_pc;
  logic        commit_bd;
  logic        commit_exc_valid;
  logic [4:0]  commit_exc_code;
  logic        commit_refill;
  logic [31:0] commit_badva;
  logic        commit_badva_valid;
  logic        commit_eret;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  // Producer side: commit stage plus fetch.
  modport master (
    output commit_valid, commit_pc, commit_bd, commit_exc_valid, commit_exc_code,
           commit_refill, commit_badva, commit_badva_valid, commit_eret, redirect_ready,
    input  commit_ready, redirect_valid, redirect_pc
  );

  // Sequencer side.
  modport slave (
    input  commit_valid, commit_pc, commit_bd, commit_exc_valid, commit_exc_code,
           commit_refill, commit_badva, commit_badva_valid, commit_eret, redirect_ready,
    output commit_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exc_ctrl.sv
// Precise exception/interrupt/ERET sequencer between commit and cp0.
// Optional event counters are built when EXC_CTRL_STATS_EN is defined;
// otherwise exc_count/int_count are constant zero.
module exc_ctrl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  hw_int_async,
  output logic [4:0]  hw_int_sync,
  exc_ctrl_if.slave   bus,
  input  logic        interrupt_pending,
  input  logic [31:0] cp0_epc,
  input  logic [31:0] exc_handler,
  input  logic [31:0] int_handler,
  input  logic [31:0] tlb_refill_handler,
  output logic        exp_en,
  output logic        exp_bd,
  output logic [31:0] exp_epc,
  output logic [4:0]  exp_exccode,
  output logic [31:0] exp_badvaddr,
  output logic        exp_badvaddr_we,
  output logic        clear_exl,
  output logic        flush,
  output logic [31:0] exc_count,
  output logic [31:0] int_count
);

  localparam int unsigned XW = 32;
  localparam int unsigned CW = 5;

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t          state, state_n;
  logic            commit_ready_n;
  logic            exp_en_n, exp_bd_n, exp_badvaddr_we_n, clear_exl_n, flush_n;
  logic [XW-1:0]   exp_epc_n, exp_badvaddr_n, redirect_pc_n;
  logic [CW-1:0]   exp_exccode_n;
  logic            redirect_valid_n;
  logic            take_int_n, take_exc_n;

  // Next-state and registered-output decode.
  always_comb begin
    state_n           = state;
    commit_ready_n    = bus.commit_ready;
    exp_en_n          = 1'b0;
    clear_exl_n       = 1'b0;
    flush_n           = 1'b0;
    exp_bd_n          = exp_bd;
    exp_epc_n         = exp_epc;
    exp_exccode_n     = exp_exccode;
    exp_badvaddr_n    = exp_badvaddr;
    exp_badvaddr_we_n = exp_badvaddr_we;
    redirect_valid_n  = bus.redirect_valid;
    redirect_pc_n     = bus.redirect_pc;
    take_int_n        = 1'b0;
    take_exc_n        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.commit_valid &&
            (interrupt_pending || bus.commit_exc_valid || bus.commit_eret)) begin
          state_n          = REDIRECT;
          commit_ready_n   = 1'b0;
          flush_n          = 1'b0 | 1'b1;
          redirect_valid_n = 1'b1;
          if (interrupt_pending || bus.commit_exc_valid) begin
            exp_en_n       = 1'b1;
            exp_bd_n       = bus.commit_bd;
            exp_epc_n      = bus.commit_bd ? bus.commit_pc - XW'(4) : bus.commit_pc;
            exp_badvaddr_n = bus.commit_badva;
            if (interrupt_pending) begin
              take_int_n        = 1'b1;
              exp_exccode_n     = '0;
              exp_badvaddr_we_n = 1'b0;
              redirect_pc_n     = int_handler;
            end else begin
              take_exc_n        = 1'b1;
              exp_exccode_n     = bus.commit_exc_code;
              exp_badvaddr_we_n = bus.commit_badva_valid;
              redirect_pc_n     = bus.commit_refill ? tlb_refill_handler : exc_handler;
            end
          end else begin
            clear_exl_n   = 1'b1;
            redirect_pc_n = cp0_epc;
          end
        end
      end
      REDIRECT: begin
        if (bus.redirect_ready) begin
          state_n          = IDLE;
          commit_ready_n   = 1'b1;
          redirect_valid_n = 1'b0;
        end
      end
      default: begin
        state_n          = IDLE;
        commit_ready_n   = 1'b1;
        redirect_valid_n = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      bus.commit_ready   <= 1'b1;
      exp_en             <= 1'b0;
      exp_bd             <= 1'b0;
      exp_epc            <= '0;
      exp_exccode        <= '0;
      exp_badvaddr       <= '0;
      exp_badvaddr_we    <= 1'b0;
      clear_exl          <= 1'b0;
      flush              <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
    end else begin
      state              <= state_n;
      bus.commit_ready   <= commit_ready_n;
      exp_en             <= exp_en_n;
      exp_bd             <= exp_bd_n;
      exp_epc            <= exp_epc_n;
      exp_exccode        <= exp_exccode_n;
      exp_badvaddr       <= exp_badvaddr_n;
      exp_badvaddr_we    <= exp_badvaddr_we_n;
      clear_exl          <= clear_exl_n;
      flush              <= flush_n;
      bus.redirect_valid <= redirect_valid_n;
      bus.redirect_pc    <= redirect_pc_n;
    end
  end

  // Plain flop chain synchronizing the raw interrupt lines.
  logic [4:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= hw_int_async;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign hw_int_sync = sync_q[SYNC_STAGES-1];

`ifdef EXC_CTRL_STATS_EN
  logic [XW-1:0] exc_cnt_q, int_cnt_q;

  // Taken-event counters, updated on the same edge that raises exp_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_cnt_q <= '0;
      int_cnt_q <= '0;
    end else begin
      if (take_exc_n) exc_cnt_q <= exc_cnt_q + XW'(1);
      if (take_int_n) int_cnt_q <= int_cnt_q + XW'(1);
    end
  end

  assign exc_count = exc_cnt_q;
  assign int_count = int_cnt_q;
`else
  logic unused_take;
  assign unused_take = take_exc_n ^ take_int_n;
  assign exc_count   = '0;
  assign int_count   = '0;
`endif

endmodule
